// File: rtl/i2c_config_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_config_sequencer
//  Description : Walks a table of I2C commands. Each entry is handed to an
//                external I2C engine, NACKs and timeouts are retried a bounded
//                number of times, and read bytes are captured per entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_config_sequencer #(
  parameter int NUM_CMDS    = 4,
  parameter int MAX_RETRY   = 2,
  parameter int TIMEOUT_CYC = 24000
) (
  input  logic                   clk_12m,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NUM_CMDS*32-1:0] cmd_table,
  input  logic                   i2c_done,
  input  logic                   i2c_nack,
  input  logic [7:0]             i2c_read_data,
  output logic [7:0]             i2c_config,
  output logic [6:0]             i2c_dev_addr,
  output logic [7:0]             i2c_reg_addr,
  output logic [7:0]             i2c_reg_data,
  output logic [NUM_CMDS*8-1:0]  rd_data,
  output logic [NUM_CMDS-1:0]    rd_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [3:0]             cmd_index,
  output logic [7:0]             state_debug
);

  localparam int c_TIMER_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int c_RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_CHECK  = 3'd4,
    S_NEXT   = 3'd5,
    S_FINISH = 3'd6,
    S_FAIL   = 3'd7
  } state_t;

  state_t                 r_state;
  state_t                 w_next;

  logic                   r_done_meta;
  logic                   r_done_sync;
  logic                   r_done_prev;
  logic                   r_nack_meta;
  logic                   r_nack_sync;

  logic [7:0]             r_mode;
  logic [6:0]             r_dev;
  logic [7:0]             r_reg;
  logic [7:0]             r_wdata;
  logic [3:0]             r_cmd_index;
  logic [c_RETRY_W-1:0]   r_retry;
  logic [c_TIMER_W-1:0]   r_timer;
  logic                   r_nack_lat;
  logic [NUM_CMDS*8-1:0]  r_rd_data;
  logic [NUM_CMDS-1:0]    r_rd_valid;

  logic [7:0]             w_mode;
  logic [6:0]             w_dev;
  logic [7:0]             w_reg;
  logic [7:0]             w_wdata;
  logic                   w_done_rise;
  logic                   w_timeout;
  logic                   w_is_read;
  logic                   w_last;
  logic                   w_can_retry;

  assign w_done_rise = r_done_sync & ~r_done_prev;
  assign w_timeout   = (r_timer == c_TIMER_W'(TIMEOUT_CYC - 1));
  assign w_is_read   = (r_mode == 8'h04) || (r_mode == 8'h05) || (r_mode == 8'h06);
  assign w_last      = (r_cmd_index == 4'(NUM_CMDS - 1));
  assign w_can_retry = (r_retry < c_RETRY_W'(MAX_RETRY));

  assign i2c_dev_addr = r_dev;
  assign i2c_reg_addr = r_reg;
  assign i2c_reg_data = r_wdata;
  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign cmd_index    = r_cmd_index;
  assign state_debug  = {5'd0, r_state};

  // Select the fields of the table entry addressed by the current index
  always_comb begin
    w_mode  = 8'd0;
    w_dev   = 7'd0;
    w_reg   = 8'd0;
    w_wdata = 8'd0;
    for (int k = 0; k < NUM_CMDS; k++) begin
      if (r_cmd_index == 4'(k)) begin
        w_mode  = cmd_table[32*k+24 +: 8];
        w_dev   = cmd_table[32*k+16 +: 7];
        w_reg   = cmd_table[32*k+8  +: 8];
        w_wdata = cmd_table[32*k    +: 8];
      end
    end
  end

  // Two-flop synchronisers for the engine handshake, plus edge history for done
  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) begin
      r_done_meta <= 1'b0;
      r_done_sync <= 1'b0;
      r_done_prev <= 1'b0;
      r_nack_meta <= 1'b0;
      r_nack_sync <= 1'b0;
    end else begin
      r_done_meta <= i2c_done;
      r_done_sync <= r_done_meta;
      r_done_prev <= r_done_sync;
      r_nack_meta <= i2c_nack;
      r_nack_sync <= r_nack_meta;
    end
  end

  // State register
  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    w_next     = r_state;
    i2c_config = 8'h00;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        busy   = 1'b1;
        w_next = (w_mode == 8'h00) ? S_FINISH : S_ISSUE;
      end
      S_ISSUE: begin
        busy       = 1'b1;
        i2c_config = r_mode;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        busy       = 1'b1;
        i2c_config = r_mode;
        if (w_done_rise || w_timeout) w_next = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (!r_nack_lat)      w_next = S_NEXT;
        else if (w_can_retry) w_next = S_ISSUE;
        else                  w_next = S_FAIL;
      end
      S_NEXT: begin
        busy   = 1'b1;
        w_next = w_last ? S_FINISH : S_LOAD;
      end
      S_FINISH: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      S_FAIL: begin
        error  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: entry latching, timeout, retry count, index and read capture
  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= 8'd0;
      r_dev       <= 7'd0;
      r_reg       <= 8'd0;
      r_wdata     <= 8'd0;
      r_cmd_index <= 4'd0;
      r_retry     <= '0;
      r_timer     <= '0;
      r_nack_lat  <= 1'b0;
      r_rd_data   <= '0;
      r_rd_valid  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cmd_index <= 4'd0;
            r_retry     <= '0;
            r_rd_valid  <= '0;
          end
        end
        S_LOAD: begin
          r_mode  <= w_mode;
          r_dev   <= w_dev;
          r_reg   <= w_reg;
          r_wdata <= w_wdata;
        end
        S_ISSUE: begin
          r_timer <= '0;
        end
        S_WAIT: begin
          r_timer <= r_timer + 1'b1;
          // A timeout is folded into the NACK path so CHECK handles both alike
          if (w_done_rise)    r_nack_lat <= r_nack_sync;
          else if (w_timeout) r_nack_lat <= 1'b1;
        end
        S_CHECK: begin
          if (!r_nack_lat) begin
            if (w_is_read) begin
              for (int k = 0; k < NUM_CMDS; k++) begin
                if (r_cmd_index == 4'(k)) begin
                  r_rd_data[8*k +: 8] <= i2c_read_data;
                  r_rd_valid[k]       <= 1'b1;
                end
              end
            end
          end else if (w_can_retry) begin
            r_retry <= r_retry + 1'b1;
          end
        end
        S_NEXT: begin
          r_retry <= '0;
          if (!w_last) r_cmd_index <= r_cmd_index + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_config_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_config_sequencer
//  Description : Scoreboard bench for i2c_config_sequencer with a behavioural
//                I2C engine and a table-walking reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_config_sequencer;

  localparam int NUM_CMDS    = 4;
  localparam int MAX_RETRY   = 2;
  localparam int TIMEOUT_CYC = 40;
  localparam int R_ACK = 0, R_NACK = 1, R_TMO = 2;

  typedef struct {int kind; logic [7:0] data; int dly;} resp_t;
  typedef struct {logic [7:0] cfg; logic [6:0] dev; logic [7:0] rg; logic [7:0] wd; int dur;} txn_t;
  typedef struct {logic is_err; logic [3:0] idx; logic [3:0] rv; logic [31:0] rd;} res_t;

  logic                   clk_12m = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic [NUM_CMDS*32-1:0] cmd_table = '0;
  logic                   i2c_done = 1'b0;
  logic                   i2c_nack = 1'b0;
  logic [7:0]             i2c_read_data = 8'd0;
  logic [7:0]             i2c_config;
  logic [6:0]             i2c_dev_addr;
  logic [7:0]             i2c_reg_addr;
  logic [7:0]             i2c_reg_data;
  logic [NUM_CMDS*8-1:0]  rd_data;
  logic [NUM_CMDS-1:0]    rd_valid;
  logic                   busy, done, error;
  logic [3:0]             cmd_index;
  logic [7:0]             state_debug;

  int n_vec = 0;
  int n_err = 0;

  resp_t preset_q[$];
  resp_t resp_q[$];
  txn_t  exp_txn_q[$];
  res_t  res_q[$];

  i2c_config_sequencer #(
    .NUM_CMDS(NUM_CMDS), .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_12m(clk_12m), .rst_n(rst_n), .start(start), .cmd_table(cmd_table),
    .i2c_done(i2c_done), .i2c_nack(i2c_nack), .i2c_read_data(i2c_read_data),
    .i2c_config(i2c_config), .i2c_dev_addr(i2c_dev_addr), .i2c_reg_addr(i2c_reg_addr),
    .i2c_reg_data(i2c_reg_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .error(error), .cmd_index(cmd_index),
    .state_debug(state_debug)
  );

  always #41 clk_12m = ~clk_12m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic resp_t mk(input int kind, input logic [7:0] data, input int dly);
    resp_t r;
    r.kind = kind; r.data = data; r.dly = dly;
    return r;
  endfunction

  function automatic resp_t rand_resp();
    int p;
    p = $urandom_range(0, 9);
    return mk((p < 7) ? R_ACK : (p < 9) ? R_NACK : R_TMO, 8'($urandom), $urandom_range(2, 10));
  endfunction

  // Reference model: walk the table, consuming one engine response per attempt
  task automatic build_pass(input logic [NUM_CMDS*32-1:0] tbl);
    res_t  r;
    resp_t rs;
    txn_t  t;
    logic [31:0] ent;
    logic  stop;
    int    tries;
    r.is_err = 1'b0; r.idx = 4'(NUM_CMDS - 1); r.rv = '0; r.rd = '0;
    stop = 1'b0;
    for (int k = 0; k < NUM_CMDS && !stop; k++) begin
      ent = tbl[32*k +: 32];
      if (ent[31:24] == 8'h00) begin
        r.idx = 4'(k);
        stop  = 1'b1;
      end else begin
        tries = 0;
        while (!stop) begin
          rs = (preset_q.size() > 0) ? preset_q.pop_front() : rand_resp();
          resp_q.push_back(rs);
          t.cfg = ent[31:24]; t.dev = ent[22:16]; t.rg = ent[15:8]; t.wd = ent[7:0];
          t.dur = (rs.kind == R_TMO) ? TIMEOUT_CYC + 1 : 0;
          exp_txn_q.push_back(t);
          if (rs.kind == R_ACK) begin
            if (ent[31:24] >= 8'h04 && ent[31:24] <= 8'h06) begin
              r.rv[k] = 1'b1;
              r.rd[8*k +: 8] = rs.data;
            end
            break;
          end else if (tries < MAX_RETRY) begin
            tries++;
          end else begin
            r.is_err = 1'b1;
            r.idx    = 4'(k);
            stop     = 1'b1;
          end
        end
      end
    end
    preset_q.delete();
    res_q.push_back(r);
  endtask

  // Behavioural I2C engine: answers each issued command from resp_q
  initial begin
    resp_t rs;
    forever begin
      @(negedge clk_12m);
      if (rst_n && i2c_config != 8'h00) begin
        if (resp_q.size() == 0) begin
          n_err++;
          $display("FAIL engine_unexpected_issue actual=0x%0h required=none", i2c_config);
          rs = mk(R_ACK, 8'h00, 3);
        end else begin
          rs = resp_q.pop_front();
        end
        if (rs.kind != R_TMO) begin
          repeat (rs.dly) @(negedge clk_12m);
          i2c_nack      = (rs.kind == R_NACK);
          i2c_read_data = rs.data;
          i2c_done      = 1'b1;
        end
        for (int c = 0; c < 500 && rst_n && i2c_config != 8'h00; c++) @(negedge clk_12m);
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
      end
    end
  end

  // Monitor: compares each issued transaction and each pass result
  initial begin
    logic act = 1'b0;
    int   dur = 0;
    txn_t cur, e;
    res_t r;
    forever begin
      @(negedge clk_12m);
      if (!rst_n) begin
        act = 1'b0;
      end else begin
        if (i2c_config != 8'h00) begin
          if (!act) begin
            act = 1'b1; dur = 0;
            cur.cfg = i2c_config; cur.dev = i2c_dev_addr; cur.rg = i2c_reg_addr; cur.wd = i2c_reg_data;
          end
          dur++;
        end else if (act) begin
          act = 1'b0;
          if (exp_txn_q.size() == 0) begin
            chk("txn_unexpected", 32'(cur.cfg), 32'h0);
          end else begin
            e = exp_txn_q.pop_front();
            chk("txn_config", 32'(cur.cfg), 32'(e.cfg));
            chk("txn_dev", 32'(cur.dev), 32'(e.dev));
            chk("txn_reg", 32'(cur.rg), 32'(e.rg));
            chk("txn_wdata", 32'(cur.wd), 32'(e.wd));
            if (e.dur != 0) chk("timeout_duration", 32'(dur), 32'(e.dur));
          end
        end
        if (done || error) begin
          if (res_q.size() == 0) begin
            chk("result_unexpected", {30'd0, done, error}, 32'h0);
          end else begin
            r = res_q.pop_front();
            chk("done_pulse", 32'(done), 32'(!r.is_err));
            chk("error_pulse", 32'(error), 32'(r.is_err));
            chk("end_busy", 32'(busy), 32'h0);
            chk("end_cmd_index", 32'(cmd_index), 32'(r.idx));
            chk("end_rd_valid", 32'(rd_valid), 32'(r.rv));
            for (int k = 0; k < NUM_CMDS; k++)
              if (r.rv[k]) chk("end_rd_byte", 32'(rd_data[8*k +: 8]), 32'(r.rd[8*k +: 8]));
          end
        end
      end
    end
  end

  task automatic run_pass(input logic [NUM_CMDS*32-1:0] tbl);
    int c;
    cmd_table = tbl;
    build_pass(tbl);
    @(negedge clk_12m); start = 1'b1;
    @(negedge clk_12m); start = 1'b0;
    if (tbl[31:24] != 8'h00) begin
      // stray start while busy must not restart the pass
      repeat (2) @(negedge clk_12m);
      start = 1'b1;
      @(negedge clk_12m); start = 1'b0;
    end
    for (c = 0; c < 4000; c++) begin
      if (done || error) break;
      @(negedge clk_12m);
    end
    if (c >= 4000) chk("pass_timeout", 32'h1, 32'h0);
    repeat (3) @(negedge clk_12m);
    chk("idle_state", 32'(state_debug), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("all_txn_issued", 32'(exp_txn_q.size()), 32'h0);
    exp_txn_q.delete(); res_q.delete(); resp_q.delete();
  endtask

  function automatic logic [31:0] ent(input logic [7:0] m, input logic [6:0] d, input logic [7:0] r, input logic [7:0] w);
    return {m, 1'b0, d, r, w};
  endfunction

  function automatic logic [NUM_CMDS*32-1:0] writes4();
    logic [NUM_CMDS*32-1:0] t;
    for (int k = 0; k < NUM_CMDS; k++)
      t[32*k +: 32] = ent(8'($urandom_range(1, 3)), 7'($urandom), 8'($urandom), 8'($urandom));
    return t;
  endfunction

  initial begin
    logic [NUM_CMDS*32-1:0] tbl;
    int c;
    // reset state
    repeat (3) @(negedge clk_12m);
    chk("rst_outputs", {i2c_config, 1'b0, i2c_dev_addr, i2c_reg_addr, i2c_reg_data} | 32'(rd_data), 32'h0);
    chk("rst_status", {16'd0, state_debug, busy, done, error, rd_valid, cmd_index[0]}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_12m);
    chk("post_rst_idle", 32'(state_debug), 32'h0);

    // write then read, read returns 0x11, mode 00 terminates
    tbl = '0;
    tbl[31:0]  = ent(8'h01, 7'h50, 8'h00, 8'h11);
    tbl[63:32] = ent(8'h04, 7'h50, 8'h00, 8'h00);
    tbl[127:96] = ent(8'h01, 7'h33, 8'h44, 8'h55);
    preset_q.push_back(mk(R_ACK, 8'h99, 4));
    preset_q.push_back(mk(R_ACK, 8'h11, 5));
    run_pass(tbl);

    // entry 0 NACKed twice then ACKed
    tbl = writes4();
    preset_q.push_back(mk(R_NACK, 8'h0, 3));
    preset_q.push_back(mk(R_NACK, 8'h0, 6));
    for (int k = 0; k < 4; k++) preset_q.push_back(mk(R_ACK, 8'h0, 3));
    run_pass(tbl);

    // entry 1 NACKed three times -> error at index 1
    tbl = writes4();
    preset_q.push_back(mk(R_ACK, 8'h0, 3));
    for (int k = 0; k < 3; k++) preset_q.push_back(mk(R_NACK, 8'h0, 4));
    run_pass(tbl);

    // engine never answers -> three full-length timeouts then error
    tbl = writes4();
    for (int k = 0; k < 3; k++) preset_q.push_back(mk(R_TMO, 8'h0, 0));
    run_pass(tbl);

    // four writes all acknowledged
    tbl = writes4();
    for (int k = 0; k < 4; k++) preset_q.push_back(mk(R_ACK, 8'h0, 2 + k));
    run_pass(tbl);

    // reset during WAIT of entry 1
    tbl = writes4();
    cmd_table = tbl;
    for (int k = 0; k < 4; k++) preset_q.push_back(mk(R_ACK, 8'h0, 9));
    build_pass(tbl);
    @(negedge clk_12m); start = 1'b1;
    @(negedge clk_12m); start = 1'b0;
    for (c = 0; c < 2000; c++) begin
      if (cmd_index == 4'd1 && i2c_config != 8'h00) break;
      @(negedge clk_12m);
    end
    if (c >= 2000) chk("reach_entry1_timeout", 32'h1, 32'h0);
    repeat (2) @(negedge clk_12m);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {i2c_config, 1'b0, i2c_dev_addr, i2c_reg_addr, i2c_reg_data}, 32'h0);
    chk("midrst_status", {16'd0, state_debug, busy, done, error, rd_valid, cmd_index[0]}, 32'h0);
    chk("midrst_index", 32'(cmd_index), 32'h0);
    exp_txn_q.delete(); res_q.delete(); resp_q.delete();
    repeat (3) @(negedge clk_12m);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_12m);
    chk("postrst_waits", {24'd0, state_debug}, 32'h0);
    for (int k = 0; k < 4; k++) preset_q.push_back(mk(R_ACK, 8'h0, 3));
    run_pass(tbl);

    // randomized tables and engine behaviour
    for (int p = 0; p < 30; p++) begin
      for (int k = 0; k < NUM_CMDS; k++)
        tbl[32*k +: 32] = ent(($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 6)),
                              7'($urandom), 8'($urandom), 8'($urandom));
      run_pass(tbl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
